// File: rtl/arki_pkg.sv
// Shared constants and types for the fetch stage and its helpers.
package arki_pkg;
    localparam int          N_DEFAULT        = 64;
    localparam int          INSTR_W          = 32;
    localparam int          OP_W             = 11;
    localparam int          OP_MSB           = 31;
    localparam int          OP_LSB           = 21;
    localparam int          PC_STEP          = 4;
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } fetch_state_t;

    // Opcode field handed to the main decoder.
    function automatic logic [OP_W-1:0] op_of(input logic [INSTR_W-1:0] instr);
        return instr[OP_MSB:OP_LSB];
    endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between fetch and imem.
interface fetch_stage_if
    import arki_pkg::*;
#(
    parameter int N = N_DEFAULT
);
    logic               imem_req_o;
    logic [N-1:0]       imem_addr_o;
    logic               imem_ready_i;
    logic [INSTR_W-1:0] imem_rdata_i;

    modport master (output imem_req_o, output imem_addr_o,
                    input  imem_ready_i, input imem_rdata_i);
    modport slave  (input  imem_req_o, input imem_addr_o,
                    output imem_ready_i, output imem_rdata_i);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Priority: flush > load > hold > bubble.
// Flush and bubble only drop valid; instr/pc keep their stale contents.
module if_id_reg
    import arki_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               hold,
    input  logic               flush,
    input  logic [INSTR_W-1:0] d_instr,
    input  logic [N-1:0]       d_pc,
    output logic               q_valid,
    output logic [INSTR_W-1:0] q_instr,
    output logic [N-1:0]       q_pc
);
    // Register update with flush taking precedence over everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_valid <= 1'b0;
            q_instr <= '0;
            q_pc    <= '0;
        end else if (flush) begin
            q_valid <= 1'b0;
        end else if (load) begin
            q_valid <= 1'b1;
            q_instr <= d_instr;
            q_pc    <= d_pc;
        end else if (!hold) begin
            q_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives imem requests, handles stall
// (via a one-word skid) and branch redirect (immediate or deferred until
// the outstanding response returns).
module fetch_stage
    import arki_pkg::*;
#(
    parameter int          N        = N_DEFAULT,
    parameter logic [N-1:0] RESET_PC = N'(RESET_PC_DEFAULT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_i,
    input  logic               branch_taken_i,
    input  logic [N-1:0]       branch_target_i,
    fetch_stage_if.master      imem,
    output logic               if_valid_o,
    output logic [INSTR_W-1:0] if_instr_o,
    output logic [N-1:0]       if_pc_o,
    output logic [OP_W-1:0]    if_op_o
);
    fetch_state_t       state, state_nxt;
    logic [N-1:0]       pc, pc_nxt;
    logic [N-1:0]       redir_tgt;
    logic               redir_pend;
    logic [INSTR_W-1:0] skid;
    logic [N-1:0]       tgt_al;
    logic               ready;

    logic               skid_ld, pend_set, pend_clr;
    logic               ld, hold, flush;
    logic [INSTR_W-1:0] ld_instr;

    assign tgt_al = branch_target_i & ~N'(3);
    assign ready  = imem.imem_ready_i;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state: only a stalled, non-redirected return parks in HOLD.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_FETCH;
            S_FETCH: if (!branch_taken_i && !redir_pend && ready && stall_i)
                         state_nxt = S_HOLD;
            S_HOLD:  if (branch_taken_i || !stall_i)
                         state_nxt = S_FETCH;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: a request is outstanding exactly while in FETCH.
    always_comb begin
        imem.imem_req_o  = (state == S_FETCH);
        imem.imem_addr_o = pc;
    end

    // Datapath control: PC, skid, redirect bookkeeping and IF/ID commands.
    always_comb begin
        pc_nxt   = pc;
        skid_ld  = 1'b0;
        pend_set = 1'b0;
        pend_clr = 1'b0;
        ld       = 1'b0;
        hold     = 1'b0;
        flush    = 1'b0;
        ld_instr = imem.imem_rdata_i;
        case (state)
            S_IDLE: begin
                if (branch_taken_i) begin
                    flush  = 1'b1;
                    pc_nxt = tgt_al;
                end else begin
                    hold = 1'b1;
                end
            end
            S_FETCH: begin
                if (branch_taken_i) begin
                    flush = 1'b1;
                    if (ready) begin
                        pc_nxt   = tgt_al;
                        pend_clr = 1'b1;
                    end else begin
                        // Address must stay put until the response arrives.
                        pend_set = 1'b1;
                    end
                end else if (ready && redir_pend) begin
                    // Wrong-path response: drop it and jump.
                    flush    = 1'b1;
                    pc_nxt   = redir_tgt;
                    pend_clr = 1'b1;
                end else if (ready) begin
                    if (stall_i) begin
                        skid_ld = 1'b1;
                        hold    = 1'b1;
                    end else begin
                        ld     = 1'b1;
                        pc_nxt = pc + N'(PC_STEP);
                    end
                end else begin
                    hold = stall_i;
                end
            end
            S_HOLD: begin
                if (branch_taken_i) begin
                    flush  = 1'b1;
                    pc_nxt = tgt_al;
                end else if (stall_i) begin
                    hold = 1'b1;
                end else begin
                    ld       = 1'b1;
                    ld_instr = skid;
                    pc_nxt   = pc + N'(PC_STEP);
                end
            end
            default: hold = 1'b1;
        endcase
    end

    // PC, skid word and pending-redirect registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc         <= RESET_PC;
            skid       <= '0;
            redir_pend <= 1'b0;
            redir_tgt  <= '0;
        end else begin
            pc <= pc_nxt;
            if (skid_ld)  skid <= imem.imem_rdata_i;
            if (pend_set) begin
                redir_pend <= 1'b1;
                redir_tgt  <= tgt_al;
            end else if (pend_clr) begin
                redir_pend <= 1'b0;
            end
        end
    end

    if_id_reg #(.N(N)) u_if_id (
        .clk     (clk),
        .reset   (reset),
        .load    (ld),
        .hold    (hold),
        .flush   (flush),
        .d_instr (ld_instr),
        .d_pc    (pc),
        .q_valid (if_valid_o),
        .q_instr (if_instr_o),
        .q_pc    (if_pc_o)
    );

    assign if_op_o = op_of(if_instr_o);
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, async reset, then random
// stimulus against a behavioural model of the fetch rules.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall_i = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic [63:0] branch_target_i = '0;
    logic        if_valid_o;
    logic [31:0] if_instr_o;
    logic [63:0] if_pc_o;
    logic [10:0] if_op_o;

    int n_chk = 0;
    int n_err = 0;

    fetch_stage_if #(.N(64)) imem ();

    fetch_stage #(.N(64), .RESET_PC(64'h0)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall_i         (stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .imem            (imem.master),
        .if_valid_o      (if_valid_o),
        .if_instr_o      (if_instr_o),
        .if_pc_o         (if_pc_o),
        .if_op_o         (if_op_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        stall, ready, br;
        logic [63:0] tgt;
        logic [31:0] rdata;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_valid;
        logic [63:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic r, input logic b,
                                input logic [63:0] t, input logic [31:0] d,
                                input logic eq, input logic [63:0] ea,
                                input logic ev, input logic [63:0] ep,
                                input logic [31:0] ei);
        vec_t v;
        v.stall = s; v.ready = r; v.br = b; v.tgt = t; v.rdata = d;
        v.e_req = eq; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_instr = ei;
        return v;
    endfunction

    // Behavioural model of the fetch rules.
    bit          m_run, m_parked, m_pend, m_v;
    logic [63:0] m_pc, m_ptgt, m_p;
    logic [31:0] m_skid, m_i;

    task automatic model_step(input bit st, input bit rdy, input bit br,
                              input logic [63:0] tgt, input logic [31:0] d);
        logic [63:0] al;
        al = {tgt[63:2], 2'b00};
        if (!m_run) begin
            m_run = 1;
            if (br) begin m_v = 0; m_pc = al; end
        end else if (m_parked) begin
            if (br) begin
                m_v = 0; m_pc = al; m_parked = 0;
            end else if (!st) begin
                m_v = 1; m_i = m_skid; m_p = m_pc; m_pc = m_pc + 4; m_parked = 0;
            end
        end else begin
            if (br) begin
                m_v = 0;
                if (rdy) begin m_pc = al; m_pend = 0; end
                else     begin m_pend = 1; m_ptgt = al; end
            end else if (rdy && m_pend) begin
                m_pc = m_ptgt; m_pend = 0;
                if (!st) m_v = 0;
            end else if (rdy) begin
                if (st) begin m_skid = d; m_parked = 1; end
                else begin m_v = 1; m_i = d; m_p = m_pc; m_pc = m_pc + 4; end
            end else if (!st) begin
                m_v = 0;
            end
        end
    endtask

    vec_t vt[22];

    initial begin
        logic [31:0] ei;
        logic [10:0] eop;

        vt[0]  = mk(0,1,0,64'h0,  32'hF8400099, 1,64'h0,   0,64'h0,  32'h0);
        vt[1]  = mk(0,1,0,64'h0,  32'hF8400000, 1,64'h4,   1,64'h0,  32'hF8400000);
        vt[2]  = mk(0,1,0,64'h0,  32'hF8400001, 1,64'h8,   1,64'h4,  32'hF8400001);
        vt[3]  = mk(0,1,0,64'h0,  32'hF8400002, 1,64'hC,   1,64'h8,  32'hF8400002);
        vt[4]  = mk(0,1,0,64'h0,  32'hF8400003, 1,64'h10,  1,64'hC,  32'hF8400003);
        vt[5]  = mk(1,1,0,64'h0,  32'hF8400004, 0,64'h10,  1,64'hC,  32'hF8400003);
        vt[6]  = mk(1,1,0,64'h0,  32'hAAAAAAAA, 0,64'h10,  1,64'hC,  32'hF8400003);
        vt[7]  = mk(1,0,0,64'h0,  32'h0,        0,64'h10,  1,64'hC,  32'hF8400003);
        vt[8]  = mk(0,1,0,64'h0,  32'hBBBBBBBB, 1,64'h14,  1,64'h10, 32'hF8400004);
        vt[9]  = mk(0,0,0,64'h0,  32'h0,        1,64'h14,  0,64'h0,  32'h0);
        vt[10] = mk(0,0,0,64'h0,  32'h0,        1,64'h14,  0,64'h0,  32'h0);
        vt[11] = mk(0,1,0,64'h0,  32'hF8400005, 1,64'h18,  1,64'h14, 32'hF8400005);
        vt[12] = mk(0,0,1,64'h103,32'h0,        1,64'h18,  0,64'h0,  32'h0);
        vt[13] = mk(0,0,0,64'h0,  32'h0,        1,64'h18,  0,64'h0,  32'h0);
        vt[14] = mk(0,1,0,64'h0,  32'hDEADBEEF, 1,64'h100, 0,64'h0,  32'h0);
        vt[15] = mk(0,1,0,64'h0,  32'hF8400006, 1,64'h104, 1,64'h100,32'hF8400006);
        vt[16] = mk(1,1,0,64'h0,  32'h11111111, 0,64'h104, 1,64'h100,32'hF8400006);
        vt[17] = mk(1,0,1,64'h40, 32'h0,        1,64'h40,  0,64'h0,  32'h0);
        vt[18] = mk(0,1,0,64'h0,  32'hF8400007, 1,64'h44,  1,64'h40, 32'hF8400007);
        vt[19] = mk(0,1,1,64'hFFFF_FFFF_FFFF_FFFF, 32'h22222222,
                    1,64'hFFFF_FFFF_FFFF_FFFC, 0,64'h0, 32'h0);
        vt[20] = mk(0,1,0,64'h0,  32'hF8400008, 1,64'h0,   1,64'hFFFF_FFFF_FFFF_FFFC, 32'hF8400008);
        vt[21] = mk(0,1,0,64'h0,  32'hF8400009, 1,64'h4,   1,64'h0,  32'hF8400009);

        imem.imem_ready_i = 1'b0;
        imem.imem_rdata_i = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_req",   {63'd0, imem.imem_req_o}, 64'd0);
        chk("rst_addr",  imem.imem_addr_o, 64'h0);
        chk("rst_valid", {63'd0, if_valid_o}, 64'd0);
        chk("rst_instr", {32'd0, if_instr_o}, 64'd0);
        chk("rst_pc",    if_pc_o, 64'd0);
        reset = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 22; i++) begin
            stall_i = vt[i].stall;
            imem.imem_ready_i = vt[i].ready;
            branch_taken_i = vt[i].br;
            branch_target_i = vt[i].tgt;
            imem.imem_rdata_i = vt[i].rdata;
            @(negedge clk);
            chk($sformatf("v%0d_req", i),   {63'd0, imem.imem_req_o}, {63'd0, vt[i].e_req});
            chk($sformatf("v%0d_addr", i),  imem.imem_addr_o, vt[i].e_addr);
            chk($sformatf("v%0d_valid", i), {63'd0, if_valid_o}, {63'd0, vt[i].e_valid});
            if (vt[i].e_valid) begin
                ei  = vt[i].e_instr;
                eop = ei[31:21];
                chk($sformatf("v%0d_pc", i),    if_pc_o, vt[i].e_pc);
                chk($sformatf("v%0d_instr", i), {32'd0, if_instr_o}, {32'd0, ei});
                chk($sformatf("v%0d_op", i),    {53'd0, if_op_o}, {53'd0, eop});
            end
        end

        // Async reset while a request is outstanding.
        stall_i = 0; branch_taken_i = 0; imem.imem_ready_i = 0;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("areset_req",   {63'd0, imem.imem_req_o}, 64'd0);
        chk("areset_valid", {63'd0, if_valid_o}, 64'd0);
        chk("areset_instr", {32'd0, if_instr_o}, 64'd0);
        chk("areset_pc",    if_pc_o, 64'd0);
        chk("areset_addr",  imem.imem_addr_o, 64'h0);
        @(negedge clk);
        reset = 1'b1;
        imem.imem_ready_i = 1'b1;           // must be ignored in idle
        imem.imem_rdata_i = 32'h33333333;
        @(negedge clk);
        chk("post_rst_req",   {63'd0, imem.imem_req_o}, 64'd1);
        chk("post_rst_addr",  imem.imem_addr_o, 64'h0);
        chk("post_rst_valid", {63'd0, if_valid_o}, 64'd0);
        imem.imem_rdata_i = 32'hF840000A;
        @(negedge clk);
        chk("post_rst_first_pc",    if_pc_o, 64'h0);
        chk("post_rst_first_instr", {32'd0, if_instr_o}, 64'hF840000A);
        chk("post_rst_next_addr",   imem.imem_addr_o, 64'h4);

        // Random phase against the model.
        m_run = 1; m_parked = 0; m_pend = 0; m_ptgt = '0; m_skid = '0;
        m_pc = 64'h4; m_v = 1; m_i = 32'hF840000A; m_p = 64'h0;
        for (int c = 0; c < 600; c++) begin
            bit          st, rdy, br;
            logic [63:0] tgt;
            logic [31:0] d;
            logic [10:0] mop;
            st  = ($urandom_range(0, 99) < 25);
            rdy = ($urandom_range(0, 99) < 60);
            br  = ($urandom_range(0, 99) < 8);
            tgt = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            d   = $urandom;
            stall_i = st; imem.imem_ready_i = rdy; branch_taken_i = br;
            branch_target_i = tgt; imem.imem_rdata_i = d;
            model_step(st, rdy, br, tgt, d);
            @(negedge clk);
            mop = m_i[31:21];
            chk("rnd_req",   {63'd0, imem.imem_req_o}, {63'd0, (m_run && !m_parked)});
            chk("rnd_addr",  imem.imem_addr_o, m_pc);
            chk("rnd_valid", {63'd0, if_valid_o}, {63'd0, m_v});
            chk("rnd_instr", {32'd0, if_instr_o}, {32'd0, m_i});
            chk("rnd_pc",    if_pc_o, m_p);
            chk("rnd_op",    {53'd0, if_op_o}, {53'd0, mop});
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register; sits directly upstream of the main decoder and feeds it the opcode field.
- Owns the PC and issues requests to a variable-latency instruction memory over a req/ready handshake.
- Presents one valid instruction per accepted fetch.
- Honours decode-stage stall and execute-stage branch redirect; redirect flushes wrong-path instructions.

Parameters:
- N, 64, datapath/PC width in bits.
- RESET_PC, 64'h0, PC value loaded on reset (bits [1:0] must be 0).

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low; 0 resets all state immediately.
- stall_i  in  1  decode cannot accept; IF/ID must hold.
- branch_taken_i  in  1  redirect request (PCSrc) from execute.
- branch_target_i  in  N  redirect address; bits [1:0] ignored (forced 0).
- imem_req_o  out  1  fetch request valid.
- imem_addr_o  out  N  fetch address; equals PC.
- imem_ready_i  in  1  memory returns data this cycle for the outstanding request.
- imem_rdata_i  in  32  instruction word, valid when imem_ready_i=1.
- if_valid_o  out  1  IF/ID holds a real instruction (0 = bubble).
- if_instr_o  out  32  IF/ID instruction.
- if_pc_o  out  N  IF/ID PC of that instruction.
- if_op_o  out  11  if_instr_o[31:21], opcode to main decoder.

Behaviour:
- Reset (reset=0, async): state=S_IDLE, pc=RESET_PC, imem_req_o=0, if_valid_o=0, if_instr_o=0, if_pc_o=0, skid=0, redir_pend=0.
- FSM states:
  - S_IDLE: req=0; next cycle -> S_FETCH.
  - S_FETCH: req=1, addr=pc.
  - S_HOLD: req=0; one fetched word parked in skid register.
- Handshake: while req=1 and ready=0, addr must stay stable. ready is only sampled when req=1; ready in S_IDLE/S_HOLD is ignored. One request outstanding max.
- S_FETCH, ready=1, no redirect (branch_taken_i=0 and redir_pend=0):
  - stall_i=0: IF/ID <= {1, rdata, pc}; pc <= pc+4; stay S_FETCH. Back-to-back fetch with zero-wait memory yields one instruction/cycle.
  - stall_i=1: skid <= rdata; IF/ID holds; -> S_HOLD.
- S_FETCH, ready=0: if stall_i=0, if_valid_o <= 0 (bubble); else IF/ID holds.
- S_HOLD:
  - stall_i=0: IF/ID <= {1, skid, pc}; pc <= pc+4; -> S_FETCH.
  - stall_i=1: hold everything.
- Redirect (branch_taken_i=1), priority over stall:
  - if_valid_o <= 0 same edge (flush), regardless of stall_i.
  - S_FETCH with ready=1 or S_HOLD: discard returned/skid word; pc <= {target[N-1:2],2'b00}; -> S_FETCH (new request next cycle).
  - S_FETCH with ready=0: latch redir_tgt, set redir_pend; addr stays stable. When ready arrives, discard data, pc <= redir_tgt, clear redir_pend.
  - Repeated redirects while pending: latest target wins.
- Flushed or discarded words never reach IF/ID.
- PC arithmetic: modulo 2^N; pc = 2^N-4 wraps to 0.
- if_op_o is purely combinational from if_instr_o; a bubble keeps its stale instr but valid=0.
- Reset mid-request: the outstanding response is dropped; after release, first request is RESET_PC. ready in S_IDLE is ignored.

Decomposition:
- Shared package arki_pkg: constants N default, INSTR_W=32, OP_W=11, OP_MSB=31, OP_LSB=21, PC_STEP=4, RESET_PC; enum fetch_state_t {S_IDLE, S_FETCH, S_HOLD}.
- Natural sub-module: if_id_reg (valid/instr/pc register with load, hold, flush inputs, flush over hold); FSM and PC live in fetch_stage.

Test Plan:
- Zero-wait stream: ready=1 always, rdata = 0xF8400000+k, RESET_PC=0 -> from 2nd cycle after reset release, if_pc_o = 0,4,8,...; valid=1 each cycle; if_op_o=11'b111_1100_0010.
- 2-cycle latency: ready every 3rd cycle -> addr stable while waiting; valid pattern 1,0,0 repeating; PCs increment by 4 per valid.
- Stall with data arriving: stall_i=1 for 3 cycles as ready=1 at pc=0x10 -> enter S_HOLD, req=0, IF/ID holds pc 0xC; on release IF/ID shows pc 0x10 with skid word; next request addr 0x14.
- Redirect with pending fetch: branch_taken_i=1, target=0x103 while waiting; ready 2 cycles later -> that word discarded, valid=0; next addr=0x100; first valid if_pc_o=0x100.
- Redirect during stall: S_HOLD plus branch_taken_i=1, stall_i=1, target=0x40 -> valid=0 next edge; skid discarded; next addr=0x40.
- Async reset mid-wait: reset=0 while req=1 pending -> outputs zero immediately without clock; after release first addr=RESET_PC; PC wrap: from pc=0xFFFF_FFFF_FFFF_FFFC, next addr=0.
